// File: rtl/net_pkg.sv
// net_pkg: shared definitions for the network link controller.
//   frame_t        44-bit link frame
//   *_LSB/_W       field positions and widths inside a frame
//   frame_fields_t unpacked view of the frame payload
//   link_state_e   transmit FSM states
//   frame_pack / frame_unpack convert between the two views (reserved bits 0)
package net_pkg;
  localparam int FRAME_W  = 44;
  localparam int POS_W    = 11;
  localparam int DIR_W    = 9;
  localparam int GAME_W   = 3;
  localparam int X_LSB    = 33;
  localparam int Y_LSB    = 21;
  localparam int DIR_LSB  = 11;
  localparam int GAME_LSB = 5;
  localparam int RST_BIT  = 3;

  typedef logic [FRAME_W-1:0] frame_t;

  typedef struct packed {
    logic [POS_W-1:0]  x;
    logic [POS_W-1:0]  y;
    logic [DIR_W-1:0]  dir;
    logic [GAME_W-1:0] game;
    logic              rst;
  } frame_fields_t;

  typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_GAP} link_state_e;

  function automatic frame_t frame_pack(input frame_fields_t f);
    frame_t fr;
    fr = '0;
    fr[X_LSB +: POS_W]     = f.x;
    fr[Y_LSB +: POS_W]     = f.y;
    fr[DIR_LSB +: DIR_W]   = f.dir;
    fr[GAME_LSB +: GAME_W] = f.game;
    fr[RST_BIT]            = f.rst;
    return fr;
  endfunction

  function automatic frame_fields_t frame_unpack(input frame_t fr);
    frame_fields_t f;
    f.x    = fr[X_LSB +: POS_W];
    f.y    = fr[Y_LSB +: POS_W];
    f.dir  = fr[DIR_LSB +: DIR_W];
    f.game = fr[GAME_LSB +: GAME_W];
    f.rst  = fr[RST_BIT];
    return f;
  endfunction
endpackage

// File: rtl/period_timer.sv
// period_timer: free-running 0..PERIOD_CYCLES-1 counter, tick high for the
// single cycle in which the counter wraps.
//   clk_in  clock
//   rst_n   async active-low reset (counter to 0)
//   tick    one-cycle wrap strobe; first one PERIOD_CYCLES edges after reset
module period_timer #(
  parameter int PERIOD_CYCLES = 833333
) (
  input  logic clk_in,
  input  logic rst_n,
  output logic tick
);
  localparam int CW = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(PERIOD_CYCLES - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n)    cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + CW'(1);
  end
endmodule

// File: rtl/net_link_ctrl.sv
// net_link_ctrl: periodic local-state broadcast and opponent-state capture.
//   clk_in, rst_n                 clock, async active-low reset
//   player_x/y, direction,
//   game_stat                     local state, snapshotted at frame launch
//   reset_req                     request RESET_REPEAT reset-flagged frames
//   tx_valid/tx_data/tx_ready     frame handshake to the transmitter
//   rx_valid/rx_data              received frames (all-zero frames ignored)
//   opp_x/y/dir/game, opp_reset   last accepted opponent state, reset edge
//   link_up                       opponent heard within TIMEOUT_TICKS ticks
//   tx_count, drop_count          frames sent (wrapping), ticks lost (sat)
module net_link_ctrl
  import net_pkg::*;
#(
  parameter int PERIOD_CYCLES = 833333,
  parameter int TIMEOUT_TICKS = 30,
  parameter int RESET_REPEAT  = 3,
  parameter int GAP_CYCLES    = 64
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic [POS_W-1:0]  player_x,
  input  logic [POS_W-1:0]  player_y,
  input  logic [DIR_W-1:0]  direction,
  input  logic [GAME_W-1:0] game_stat,
  input  logic              reset_req,
  output logic              tx_valid,
  output frame_t            tx_data,
  input  logic              tx_ready,
  input  logic              rx_valid,
  input  frame_t            rx_data,
  output logic [POS_W-1:0]  opp_x,
  output logic [POS_W-1:0]  opp_y,
  output logic [DIR_W-1:0]  opp_dir,
  output logic [GAME_W-1:0] opp_game,
  output logic              opp_reset,
  output logic              link_up,
  output logic [15:0]       tx_count,
  output logic [7:0]        drop_count
);
  localparam int RW = $clog2(RESET_REPEAT + 1);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_TICKS);

  link_state_e   state;
  logic          tick, tick_pend, prev_rst;
  logic [RW-1:0] rst_pend;
  logic [GW-1:0] gap_cnt;
  logic [TW-1:0] to_cnt;
  logic          launch_rst, launch_st, rx_take;
  frame_fields_t tx_f, rx_f;

  period_timer #(.PERIOD_CYCLES(PERIOD_CYCLES)) u_timer (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .tick   (tick)
  );

  // Reset frames win over a pending periodic frame.
  assign launch_rst = (state == ST_IDLE) && (rst_pend != '0);
  assign launch_st  = (state == ST_IDLE) && (rst_pend == '0) && tick_pend;
  assign rx_take    = rx_valid && (rx_data != '0);
  assign rx_f       = frame_unpack(rx_data);

  always_comb begin
    tx_f.x    = player_x;
    tx_f.y    = player_y;
    tx_f.dir  = direction;
    tx_f.game = game_stat;
    tx_f.rst  = launch_rst;
  end

  // Transmit FSM: tx_data is only written on launch, so it holds through HOLD.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      tx_valid <= 1'b0;
      tx_data  <= '0;
      tx_count <= '0;
      gap_cnt  <= '0;
    end else begin
      case (state)
        ST_IDLE: if (launch_rst || launch_st) begin
          tx_data  <= frame_pack(tx_f);
          tx_valid <= 1'b1;
          state    <= ST_HOLD;
        end
        ST_HOLD: if (tx_valid && tx_ready) begin
          tx_valid <= 1'b0;
          tx_count <= tx_count + 16'd1;
          gap_cnt  <= '0;
          state    <= ST_GAP;
        end
        ST_GAP: begin
          if (gap_cnt == GAP_LAST) state <= ST_IDLE;
          else                     gap_cnt <= gap_cnt + GW'(1);
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Pending work. A tick landing in the cycle its predecessor is consumed is
  // simply re-armed, not counted as a drop.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      tick_pend  <= 1'b0;
      drop_count <= '0;
      rst_pend   <= '0;
    end else begin
      if (tick) begin
        tick_pend <= 1'b1;
        if (tick_pend && !launch_st && drop_count != 8'hFF)
          drop_count <= drop_count + 8'd1;
      end else if (launch_st) begin
        tick_pend <= 1'b0;
      end
      if (reset_req)       rst_pend <= RW'(RESET_REPEAT);
      else if (launch_rst) rst_pend <= rst_pend - RW'(1);
    end
  end

  // Receive side and link supervision; an rx frame beats a same-cycle tick.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      opp_x     <= '0;
      opp_y     <= '0;
      opp_dir   <= '0;
      opp_game  <= '0;
      opp_reset <= 1'b0;
      prev_rst  <= 1'b0;
      link_up   <= 1'b0;
      to_cnt    <= '0;
    end else if (rx_take) begin
      opp_x     <= rx_f.x;
      opp_y     <= rx_f.y;
      opp_dir   <= rx_f.dir;
      opp_game  <= rx_f.game;
      opp_reset <= rx_f.rst && !prev_rst;
      prev_rst  <= rx_f.rst;
      link_up   <= 1'b1;
      to_cnt    <= '0;
    end else begin
      opp_reset <= 1'b0;
      if (tick && to_cnt != TO_MAX) begin
        to_cnt <= to_cnt + TW'(1);
        if (to_cnt == TO_MAX - TW'(1)) link_up <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_net_link_ctrl.sv
module tb_net_link_ctrl;
  localparam int P  = 100;
  localparam int TO = 4;
  localparam int RR = 3;
  localparam int G  = 8;

  logic        clk_in = 1'b0, rst_n = 1'b0;
  logic [10:0] player_x = '0, player_y = '0;
  logic [8:0]  direction = '0;
  logic [2:0]  game_stat = '0;
  logic        reset_req = 1'b0, tx_ready = 1'b0, rx_valid = 1'b0;
  logic [43:0] rx_data = '0;
  logic        tx_valid, opp_reset, link_up;
  logic [43:0] tx_data;
  logic [10:0] opp_x, opp_y;
  logic [8:0]  opp_dir;
  logic [2:0]  opp_game;
  logic [15:0] tx_count;
  logic [7:0]  drop_count;

  net_link_ctrl #(.PERIOD_CYCLES(P), .TIMEOUT_TICKS(TO), .RESET_REPEAT(RR),
                  .GAP_CYCLES(G)) dut (
    .clk_in(clk_in), .rst_n(rst_n), .player_x(player_x), .player_y(player_y),
    .direction(direction), .game_stat(game_stat), .reset_req(reset_req),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .opp_x(opp_x), .opp_y(opp_y),
    .opp_dir(opp_dir), .opp_game(opp_game), .opp_reset(opp_reset),
    .link_up(link_up), .tx_count(tx_count), .drop_count(drop_count));

  always #5 clk_in = ~clk_in;

  int n_vec = 0, n_miss = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Frame from field values with plain arithmetic.
  function automatic logic [43:0] build(input int x, input int y, input int d,
                                        input int g, input int r);
    longint v;
    v = longint'(x) * 64'h2_0000_0000 + longint'(y) * 64'd2097152 +
        longint'(d) * 64'd2048 + longint'(g) * 64'd32 + longint'(r) * 64'd8;
    return v[43:0];
  endfunction

  // Reference model: edge count since reset, a busy/gap timeline, and
  // pending-work counters.
  int          m_cyc, m_gap, m_rpend, m_txc, m_drop, m_to;
  bit          m_hold, m_tpend, m_orst, m_prev, m_link;
  logic [43:0] m_frame;
  logic [10:0] m_ox, m_oy;
  logic [8:0]  m_od;
  logic [2:0]  m_og;

  task automatic m_reset();
    m_cyc = 0; m_gap = 0; m_rpend = 0; m_txc = 0; m_drop = 0; m_to = 0;
    m_hold = 0; m_tpend = 0; m_orst = 0; m_prev = 0; m_link = 0;
    m_frame = '0; m_ox = '0; m_oy = '0; m_od = '0; m_og = '0;
  endtask

  task automatic m_step();
    bit tick, idle, lr, ls;
    longint rd;
    m_cyc++;
    tick = (m_cyc % P) == 0;
    idle = !m_hold && m_gap == 0;
    lr   = idle && m_rpend > 0;
    ls   = idle && m_rpend == 0 && m_tpend;
    if (m_hold && tx_ready) begin
      m_hold = 0; m_gap = G; m_txc = (m_txc + 1) % 65536;
    end else if (m_gap > 0) m_gap--;
    if (lr || ls) begin
      m_frame = build(int'(player_x), int'(player_y), int'(direction),
                      int'(game_stat), lr ? 1 : 0);
      m_hold = 1;
    end
    if (tick) begin
      if (m_tpend && !ls && m_drop < 255) m_drop++;
      m_tpend = 1;
    end else if (ls) m_tpend = 0;
    if (reset_req) m_rpend = RR;
    else if (lr)   m_rpend--;
    if (rx_valid && rx_data != 0) begin
      rd = longint'(rx_data);
      m_ox = 11'((rd >> 33) % 2048);
      m_oy = 11'((rd >> 21) % 2048);
      m_od = 9'((rd >> 11) % 512);
      m_og = 3'((rd >> 5) % 8);
      m_orst = ((rd >> 3) % 2 == 1) && !m_prev;
      m_prev = ((rd >> 3) % 2 == 1);
      m_link = 1; m_to = 0;
    end else begin
      m_orst = 0;
      if (tick && m_to < TO) begin
        m_to++;
        if (m_to == TO) m_link = 0;
      end
    end
  endtask

  always @(posedge clk_in or negedge rst_n)
    if (!rst_n) m_reset(); else m_step();

  always @(negedge clk_in) if (chk_en) begin
    chk("tx_valid", tx_valid, m_hold);
    chk("tx_data", tx_data, m_frame);
    chk("tx_count", tx_count, m_txc);
    chk("drop_count", drop_count, m_drop);
    chk("link_up", link_up, m_link);
    chk("opp_reset", opp_reset, m_orst);
    chk("opp_x", opp_x, m_ox);
    chk("opp_y", opp_y, m_oy);
    chk("opp_dir", opp_dir, m_od);
    chk("opp_game", opp_game, m_og);
  end

  task automatic send_rx(input logic [43:0] d);
    rx_valid = 1'b1; rx_data = d;
    @(negedge clk_in);
    rx_valid = 1'b0; rx_data = '0;
  endtask

  task automatic wait_phase(input int ph);
    int n = 0;
    while ((m_cyc % P) != ph && n < 2 * P) begin @(negedge clk_in); n++; end
  endtask

  logic [63:0] rnd;
  int stall = 0;
  int exp_rst [4] = '{1, 0, 0, 1};
  int rst_bit [4] = '{1, 1, 0, 1};

  initial begin
    m_reset();
    repeat (3) @(negedge clk_in);
    chk_en = 1'b1;
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_link", link_up, 0);
    #2 rst_n = 1'b1;

    // Fixed state, always ready: one frame per period.
    player_x = 11'd191; player_y = 11'd191; direction = 9'd270; game_stat = 3'd1;
    tx_ready = 1'b1;
    repeat (120) @(negedge clk_in);
    chk("frame_fixed", tx_data, 64'h17E17E87020);
    chk("txc_first", tx_count, 1);

    // Stall across three ticks: one frame held, one pending, one dropped.
    wait_phase(P - 1);
    tx_ready = 1'b0;
    repeat (250) @(negedge clk_in);
    chk("stall_hold", tx_valid, 1);
    chk("stall_data", tx_data, 64'h17E17E87020);
    chk("stall_drop", drop_count, 1);
    tx_ready = 1'b1;
    repeat (30) @(negedge clk_in);
    chk("stall_txc", tx_count, 3);

    // Reset request coinciding with a tick.
    wait_phase(P - 1);
    reset_req = 1'b1;
    @(negedge clk_in);
    reset_req = 1'b0;
    repeat (60) @(negedge clk_in);
    chk("rst_frames_txc", tx_count, 7);

    // Opponent reset edge detection.
    send_rx(build(5, 6, 7, 2, 0));
    @(negedge clk_in);
    for (int i = 0; i < 4; i++) begin
      send_rx(build(100 + i, 50, 180, 3, rst_bit[i]));
      chk("opp_reset_seq", opp_reset, exp_rst[i]);
      chk("opp_x_seq", opp_x, 100 + i);
      @(negedge clk_in);
    end
    chk("link_after_rx", link_up, 1);

    // Silence until timeout; zero frames must not revive the link.
    repeat (TO * P + 20) @(negedge clk_in);
    chk("link_timeout", link_up, 0);
    repeat (3) send_rx('0);
    chk("link_zero_rx", link_up, 0);

    // Randomized traffic.
    for (int c = 0; c < 4000; c++) begin
      player_x  = 11'($urandom);
      player_y  = 11'($urandom);
      direction = 9'($urandom % 360);
      game_stat = 3'($urandom);
      if (stall == 0 && $urandom % 500 == 0) stall = $urandom_range(150, 300);
      if (stall > 0) begin tx_ready = 1'b0; stall--; end
      else tx_ready = ($urandom % 4) != 0;
      reset_req = ($urandom % 400) == 0;
      rx_valid  = ($urandom % 60) == 0;
      rnd = {$urandom, $urandom};
      rx_data = (($urandom % 4) == 0) ? 44'd0 : rnd[43:0];
      @(negedge clk_in);
    end
    reset_req = 1'b0; rx_valid = 1'b0; rx_data = '0;

    // Reset asserted while a frame is held.
    send_rx(build(1, 2, 3, 4, 0));
    tx_ready = 1'b0;
    begin
      int n = 0;
      while (!tx_valid && n < 3 * P) begin @(negedge clk_in); n++; end
    end
    chk("hold_reached", tx_valid, 1);
    chk("hold_link", link_up, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_tx_valid", tx_valid, 0);
    chk("async_tx_count", tx_count, 0);
    chk("async_link", link_up, 0);
    chk("async_tx_data", tx_data, 0);
    repeat (2) @(negedge clk_in);
    #2 rst_n = 1'b1;
    tx_ready = 1'b1;
    repeat (P + 20) @(negedge clk_in);
    chk("post_rst_txc", tx_count, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
